exec_writeback_stage: RTL

//   Pipeline stage directly downstream of alu32. Registers ALU result, destination and write-enable,

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/wb_skid_buffer.sv | 106 ++++++++++
 rtl/exec_writeback_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions between alu32 and the execute/writeback stage:
//   - alu32 op_code constants
//   - bit positions of Z/C/V/S inside the 4-bit status word {S,V,C,Z}
//   - wb_entry_t: one pipeline entry travelling to the register-file port
//   - buf_state_t: occupancy of the two-entry skid buffer
//   - pack_flags: builds the {S,V,C,Z} status word from individual flags
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default widths of the datapath as built around alu32.
  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

  // alu32 op_code encoding.
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_NOR = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;

  // Bit positions inside the status word {S,V,C,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 3;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_REG_AW-1:0] dest;
    logic                 wb_en;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic [3:0] pack_flags(input logic s, input logic v,
                                            input logic c, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_S] = s;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// ---------------------------------------------------------------------------
// wb_skid_buffer
//   Two-entry valid/ready pipeline register. The main register drives the
//   output; the skid register catches one extra entry that arrives while the
//   output is stalled, so in_ready can be a register and never depends
//   combinationally on out_ready. Order is strictly preserved.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready registered, 0 only in TWO)
//   in_data         entry to store (W bits)
//   out_valid/ready downstream handshake (out_valid = main register full)
//   out_data        main register contents
// ---------------------------------------------------------------------------
module wb_skid_buffer
  import alu_pkg::*;
#(
  parameter int W = $bits(wb_entry_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   r_state;
  buf_state_t   w_state_next;
  logic         r_in_ready;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;

  logic         w_accept;
  logic         w_emit;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_skid_to_main;

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;

  assign w_accept  = in_valid & r_in_ready;
  assign w_emit    = out_valid & out_ready;

  always_comb begin
    w_state_next   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_main  = 1'b1;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_accept && !w_emit) begin
          // Output stalled: park the new entry behind the main one.
          w_load_skid  = 1'b1;
          w_state_next = TWO;
        end else if (w_emit && !w_accept) begin
          w_state_next = EMPTY;
        end else if (w_emit && w_accept) begin
          // Main drains and refills in the same cycle.
          w_load_main  = 1'b1;
        end
      end
      TWO: begin
        // in_ready is 0 here, so only a drain can happen.
        if (w_emit) begin
          w_skid_to_main = 1'b1;
          w_state_next   = ONE;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_next;
      // Registered ready: look ahead at the next occupancy.
      r_in_ready <= (w_state_next != TWO);
      if (w_load_main) begin
        r_main <= in_data;
      end else if (w_skid_to_main) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/exec_writeback_stage.sv
// ---------------------------------------------------------------------------
// exec_writeback_stage
//   Stage directly after alu32. Buffers {result, destination, write-enable}
//   through a two-entry skid buffer, commits the ALU flags into the status
//   register at accept time, feeds the committed carry back to alu32 and
//   raises a sticky exception when an accepted op carries alu_error.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           upstream handshake (in_ready registered)
//   alu_data, alu_zero/carry/ovf/sign, alu_error   alu32 outputs
//   in_dest, in_wb_en, in_flags_we                 op side-band
//   out_valid/out_ready         downstream handshake
//   out_data, out_dest, out_wb_en                  register-file write port
//   flags                       committed {S,V,C,Z}
//   carry_fb                    committed carry, to alu32 carry_in
//   exc, exc_clear              sticky error exception and its clear
// ---------------------------------------------------------------------------
module exec_writeback_stage
  import alu_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         REG_AW   = 5,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              alu_sign,
  input  logic              alu_error,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_wb_en,
  input  logic              in_flags_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wb_en,
  output logic [3:0]        flags,
  output logic              carry_fb,
  output logic              exc,
  input  logic              exc_clear
);

  // Entry layout matches wb_entry_t when the default widths are used.
  localparam int ENTRY_W = DATA_W + REG_AW + 1;

  logic [ENTRY_W-1:0] w_in_entry;
  logic [ENTRY_W-1:0] w_out_entry;
  logic               w_accept;
  logic [3:0]         w_alu_flags;
  logic [3:0]         r_flags;
  logic               r_exc;

  assign w_accept = in_valid & in_ready;

  // An erroring op still travels down the pipe so ordering is kept, but it
  // must never write the register file.
  assign w_in_entry = {alu_data, in_dest, in_wb_en & ~alu_error};

  wb_skid_buffer #(
    .W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_entry)
  );

  assign {out_data, out_dest, out_wb_en} = w_out_entry;

  assign w_alu_flags = pack_flags(alu_sign, alu_ovf, alu_carry, alu_zero);

  // Flags commit when the op is accepted, not when it leaves, so the ALU
  // sees the new carry on the very next op regardless of downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= FLAG_RST;
    end else if (w_accept && in_flags_we && !alu_error) begin
      r_flags <= w_alu_flags;
    end
  end

  // Setting has priority over clearing so an error arriving together with
  // a clear is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc <= 1'b0;
    end else if (w_accept && alu_error) begin
      r_exc <= 1'b1;
    end else if (exc_clear) begin
      r_exc <= 1'b0;
    end
  end

  assign flags    = r_flags;
  assign carry_fb = r_flags[FLAG_C];
  assign exc      = r_exc;

endmodule
